// File: rtl/cnnip_axi_pkg.sv
// Shared types for the convolution IP AXI4-Lite front end.
package cnnip_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_EXEC,
    WR_RESP,
    RD_ISSUE,
    RD_WAIT,
    RD_RESP
  } bridge_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/cnnip_mem_if.sv
// Single-cycle memory access port between the bridge and the address decoder.
interface cnnip_mem_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  en;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  valid;

  modport master (output en, we, addr, din, input dout, valid);
  modport slave  (input en, we, addr, din, output dout, valid);
endinterface

// File: rtl/axi4l_mem_bridge.sv
// AXI4-Lite slave that turns host reads/writes into one-pulse cnnip_mem_if
// accesses, one transaction at a time, alternating reads and writes.
//
// state    | meaning
// IDLE     | accept AW/W/AR, arbitrate read vs. pending write
// WR_EXEC  | one-cycle write pulse (suppressed on partial strobe)
// WR_RESP  | B channel valid until bready
// RD_ISSUE | one-cycle read pulse
// RD_WAIT  | wait for mem valid or timeout
// RD_RESP  | R channel valid until rready
module axi4l_mem_bridge
  import cnnip_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int RD_TIMEOUT = 16
) (
  input  logic                    clk_a,
  input  logic                    srst_aq,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  cnnip_mem_if.master             to_mem_if
);

  localparam logic [7:0] TO_LAST = 8'(RD_TIMEOUT - 1);

  bridge_state_t           state_q, state_d;
  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic                    prio_wr_q, prio_wr_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [7:0]              to_cnt_q, to_cnt_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic                    wr_pend;
  logic                    aw_hs, w_hs, ar_hs;
  logic                    mem_en, mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_din;

  assign wr_pend = aw_held_q & w_held_q;

  // Handshake outputs are held low while reset is asserted.
  assign s_awready = !srst_aq && (state_q == IDLE) && !aw_held_q;
  assign s_wready  = !srst_aq && (state_q == IDLE) && !w_held_q;
  assign s_arready = !srst_aq && (state_q == IDLE) && !(wr_pend && prio_wr_q);
  assign s_bvalid  = !srst_aq && (state_q == WR_RESP);
  assign s_rvalid  = !srst_aq && (state_q == RD_RESP);
  assign s_bresp   = bresp_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;
  assign ar_hs = s_arvalid && s_arready;

  assign to_mem_if.en   = mem_en;
  assign to_mem_if.we   = mem_we;
  assign to_mem_if.addr = mem_addr;
  assign to_mem_if.din  = mem_din;

  always_comb begin
    state_d   = state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    prio_wr_d = prio_wr_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    araddr_d  = araddr_q;
    to_cnt_d  = to_cnt_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;

    if (aw_hs) begin
      awaddr_d  = s_awaddr;
      aw_held_d = 1'b1;
    end
    if (w_hs) begin
      wdata_d  = s_wdata;
      wstrb_d  = s_wstrb;
      w_held_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (ar_hs) begin
          araddr_d  = s_araddr;
          prio_wr_d = 1'b1;
          state_d   = RD_ISSUE;
        end else if (wr_pend) begin
          prio_wr_d = 1'b0;
          state_d   = WR_EXEC;
        end
      end
      WR_EXEC: begin
        // Partial-strobe writes are rejected rather than read-modify-written.
        if (&wstrb_q) begin
          mem_en   = 1'b1;
          mem_we   = 1'b1;
          mem_addr = awaddr_q;
          mem_din  = wdata_q;
          bresp_d  = RESP_OKAY;
        end else begin
          bresp_d  = RESP_SLVERR;
        end
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        state_d   = WR_RESP;
      end
      WR_RESP: begin
        if (s_bready) state_d = IDLE;
      end
      RD_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = araddr_q;
        to_cnt_d = '0;
        if (to_mem_if.valid) begin
          rdata_d = to_mem_if.dout;
          rresp_d = RESP_OKAY;
          state_d = RD_RESP;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (to_mem_if.valid) begin
          rdata_d = to_mem_if.dout;
          rresp_d = RESP_OKAY;
          state_d = RD_RESP;
        end else if (to_cnt_q == TO_LAST) begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
          state_d = RD_RESP;
        end else if (to_cnt_q != 8'hFF) begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      RD_RESP: begin
        if (s_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_a) begin
    if (srst_aq) begin
      state_q   <= IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      prio_wr_q <= 1'b1;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      araddr_q  <= '0;
      to_cnt_q  <= '0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      prio_wr_q <= prio_wr_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      araddr_q  <= araddr_d;
      to_cnt_q  <= to_cnt_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule
